// File: rtl/ahb_slave_pipe_pkg.sv
// rtl/ahb_slave_pipe_pkg.sv - shared encodings and map defaults for the AHB slave pipe
package ahb_slave_pipe_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [31:0] DEF_BASE     = 32'h8000_0000;
  localparam int          DEF_RGN_LOG2 = 26;

  typedef enum logic [1:0] {
    ST_OKAY = 2'b00,
    ST_ERR1 = 2'b01,
    ST_ERR2 = 2'b10
  } resp_state_t;

  // NONSEQ and SEQ both carry bit 1; IDLE and BUSY do not.
  function automatic logic is_active(input logic [1:0] trans);
    return trans[1];
  endfunction

endpackage

// File: rtl/ahb_addr_decode.sv
// rtl/ahb_addr_decode.sv - maps an address onto one of NUM_SLV equal regions above BASE
module ahb_addr_decode
  import ahb_slave_pipe_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                NUM_SLV  = 3,
  parameter logic [ADDR_W-1:0] BASE     = DEF_BASE[ADDR_W-1:0],
  parameter int                RGN_LOG2 = DEF_RGN_LOG2
) (
  input  logic [ADDR_W-1:0]  Haddr,
  output logic               mapped,
  output logic [NUM_SLV-1:0] tempselx
);

  localparam int          IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  // Span held in 64 bits so BASE + span can never wrap inside ADDR_W.
  localparam logic [63:0] SPAN  = 64'(NUM_SLV) << RGN_LOG2;

  logic [ADDR_W-1:0] offset;
  logic [IDX_W-1:0]  idx;

  always_comb begin
    offset = Haddr - BASE;
    mapped = (Haddr >= BASE) && ({{(64-ADDR_W){1'b0}}, offset} < SPAN);
    idx    = IDX_W'(offset >> RGN_LOG2);
    for (int i = 0; i < NUM_SLV; i++) begin
      tempselx[i] = mapped && (idx == IDX_W'(i));
    end
  end

endmodule

// File: rtl/ahb_slave_pipe.sv
// rtl/ahb_slave_pipe.sv - AHB slave front end: address/data pipeline, decode, two-cycle ERROR response
module ahb_slave_pipe
  import ahb_slave_pipe_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                NUM_SLV  = 3,
  parameter logic [ADDR_W-1:0] BASE     = DEF_BASE[ADDR_W-1:0],
  parameter int                RGN_LOG2 = DEF_RGN_LOG2
) (
  input  logic               Hclk,
  input  logic               Hreset,
  input  logic               Hwrite,
  input  logic               Hreadyin,
  input  logic [1:0]         Htrans,
  input  logic [ADDR_W-1:0]  Haddr,
  input  logic [DATA_W-1:0]  Hwdata,
  input  logic [DATA_W-1:0]  Prdata,
  output logic               valid,
  output logic [ADDR_W-1:0]  Haddr1,
  output logic [ADDR_W-1:0]  Haddr2,
  output logic [DATA_W-1:0]  Hwdata1,
  output logic [DATA_W-1:0]  Hwdata2,
  output logic               Hwritereg,
  output logic [NUM_SLV-1:0] tempselx,
  output logic [DATA_W-1:0]  Hrdata,
  output logic [1:0]         Hresp,
  output logic               Hreadyout,
  output logic [7:0]         err_cnt
);

  resp_state_t state, state_nxt;
  logic        mapped;
  logic        active;
  logic        err_start;

  ahb_addr_decode #(
    .ADDR_W   (ADDR_W),
    .NUM_SLV  (NUM_SLV),
    .BASE     (BASE),
    .RGN_LOG2 (RGN_LOG2)
  ) u_decode (
    .Haddr    (Haddr),
    .mapped   (mapped),
    .tempselx (tempselx)
  );

  assign active    = is_active(Htrans);
  assign valid     = Hreadyin & active & mapped & (state == ST_OKAY);
  assign err_start = Hreadyin & active & ~mapped & (state == ST_OKAY);
  assign Hrdata    = Prdata;

  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      Haddr1    <= '0;
      Haddr2    <= '0;
      Hwdata1   <= '0;
      Hwdata2   <= '0;
      Hwritereg <= 1'b0;
    end else if (Hreadyin) begin
      Haddr1    <= Haddr;
      Haddr2    <= Haddr1;
      Hwdata1   <= Hwdata;
      Hwdata2   <= Hwdata1;
      Hwritereg <= Hwrite;
    end
  end

  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      state   <= ST_OKAY;
      err_cnt <= 8'd0;
    end else begin
      state <= state_nxt;
      if (err_start && err_cnt != 8'hFF) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

  // Address phases seen in ERR1/ERR2 are never decoded: the master cancels them.
  always_comb begin
    state_nxt = state;
    Hresp     = HRESP_OKAY;
    Hreadyout = 1'b1;
    case (state)
      ST_OKAY: begin
        if (err_start) state_nxt = ST_ERR1;
      end
      ST_ERR1: begin
        Hresp     = HRESP_ERROR;
        Hreadyout = 1'b0;
        state_nxt = ST_ERR2;
      end
      ST_ERR2: begin
        Hresp     = HRESP_ERROR;
        state_nxt = ST_OKAY;
      end
      default: state_nxt = ST_OKAY;
    endcase
  end

endmodule

// File: tb/tb_ahb_slave_pipe.sv
// tb/tb_ahb_slave_pipe.sv - directed self-checking bench for ahb_slave_pipe
module tb_ahb_slave_pipe;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  logic        a_write, a_ready;
  logic [1:0]  a_trans;
  logic [31:0] a_addr, a_wdata, a_prdata;
  logic        a_valid, a_wreg, a_rdyout;
  logic [31:0] a_addr1, a_addr2, a_wd1, a_wd2, a_rdata;
  logic [2:0]  a_sel;
  logic [1:0]  a_resp;
  logic [7:0]  a_ecnt;

  logic        b_write, b_ready;
  logic [1:0]  b_trans;
  logic [31:0] b_addr, b_addr1, b_addr2;
  logic [63:0] b_wdata, b_prdata, b_wd1, b_wd2, b_rdata;
  logic        b_valid, b_wreg, b_rdyout;
  logic [7:0]  b_sel;
  logic [1:0]  b_resp;
  logic [7:0]  b_ecnt;

  int n_checks = 0;
  int n_fail   = 0;

  ahb_slave_pipe u_a (
    .Hclk(clk), .Hreset(rst), .Hwrite(a_write), .Hreadyin(a_ready), .Htrans(a_trans),
    .Haddr(a_addr), .Hwdata(a_wdata), .Prdata(a_prdata), .valid(a_valid),
    .Haddr1(a_addr1), .Haddr2(a_addr2), .Hwdata1(a_wd1), .Hwdata2(a_wd2),
    .Hwritereg(a_wreg), .tempselx(a_sel), .Hrdata(a_rdata), .Hresp(a_resp),
    .Hreadyout(a_rdyout), .err_cnt(a_ecnt)
  );

  ahb_slave_pipe #(.DATA_W(64), .NUM_SLV(8)) u_b (
    .Hclk(clk), .Hreset(rst), .Hwrite(b_write), .Hreadyin(b_ready), .Htrans(b_trans),
    .Haddr(b_addr), .Hwdata(b_wdata), .Prdata(b_prdata), .valid(b_valid),
    .Haddr1(b_addr1), .Haddr2(b_addr2), .Hwdata1(b_wd1), .Hwdata2(b_wd2),
    .Hwritereg(b_wreg), .tempselx(b_sel), .Hrdata(b_rdata), .Hresp(b_resp),
    .Hreadyout(b_rdyout), .err_cnt(b_ecnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic [1:0] trans, input logic [31:0] addr, input logic wr,
                         input logic [31:0] wd);
    a_trans = trans;
    a_addr  = addr;
    a_write = wr;
    a_wdata = wd;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    a_write = 0; a_ready = 1; a_trans = 2'b00; a_addr = 0; a_wdata = 0; a_prdata = 0;
    b_write = 0; b_ready = 1; b_trans = 2'b00; b_addr = 0; b_wdata = 0; b_prdata = 0;
    #2;
    chk("rst_hresp", a_resp, 2'b00);
    chk("rst_hreadyout", a_rdyout, 1);
    chk("rst_errcnt", a_ecnt, 0);
    chk("rst_haddr1", a_addr1, 0);
    chk("rst_hwdata2", a_wd2, 0);
    chk("rst_hwritereg", a_wreg, 0);
    @(negedge clk);
    rst = 1'b0;

    drive_a(2'b10, 32'h8000_0000, 1, 32'h1234_5678);
    chk("wr_valid", a_valid, 1);
    chk("wr_sel", a_sel, 3'b001);
    tick();
    chk("wr_haddr1", a_addr1, 32'h8000_0000);
    chk("wr_hwdata1", a_wd1, 32'h1234_5678);
    chk("wr_hwritereg", a_wreg, 1);

    a_prdata = 32'h8765_4321;
    drive_a(2'b11, 32'h8400_0000, 0, 32'h0);
    chk("rd_sel", a_sel, 3'b010);
    chk("rd_hrdata", a_rdata, 32'h8765_4321);
    chk("rd_valid", a_valid, 1);
    tick();
    chk("rd_haddr2", a_addr2, 32'h8000_0000);
    chk("rd_hwdata2", a_wd2, 32'h1234_5678);
    chk("rd_haddr1", a_addr1, 32'h8400_0000);
    chk("rd_hwritereg", a_wreg, 0);

    a_ready = 0;
    for (int i = 0; i < 3; i++) begin
      drive_a(2'b10, 32'h8000_0100 + 32'(i) * 4, 1, 32'hA5A5_0000 + 32'(i));
      chk("stall_valid", a_valid, 0);
      tick();
      chk("stall_haddr1", a_addr1, 32'h8400_0000);
      chk("stall_haddr2", a_addr2, 32'h8000_0000);
      chk("stall_hwritereg", a_wreg, 0);
    end
    a_ready = 1;

    drive_a(2'b10, 32'h8C00_0000, 0, 0);
    chk("unm_valid", a_valid, 0);
    chk("unm_sel", a_sel, 3'b000);
    chk("unm_hresp0", a_resp, 2'b00);
    tick();
    drive_a(2'b00, 32'h0, 0, 0);
    chk("err1_hresp", a_resp, 2'b01);
    chk("err1_hreadyout", a_rdyout, 0);
    chk("err1_errcnt", a_ecnt, 1);
    tick();
    chk("err2_hresp", a_resp, 2'b01);
    chk("err2_hreadyout", a_rdyout, 1);
    tick();
    chk("back_hresp", a_resp, 2'b00);
    chk("back_hreadyout", a_rdyout, 1);

    drive_a(2'b10, 32'h8BFF_FFFF, 0, 0);
    chk("top_sel", a_sel, 3'b100);
    chk("top_valid", a_valid, 1);
    drive_a(2'b10, 32'h7FFF_FFFF, 0, 0);
    chk("below_sel", a_sel, 3'b000);
    drive_a(2'b00, 32'h8C00_0000, 0, 0);
    tick();
    chk("idle_unm_hresp", a_resp, 2'b00);
    drive_a(2'b01, 32'h8C00_0000, 0, 0);
    chk("busy_valid", a_valid, 0);
    tick();
    chk("busy_unm_hresp", a_resp, 2'b00);
    chk("busy_errcnt", a_ecnt, 1);

    drive_a(2'b10, 32'h8C00_0000, 0, 0);
    tick();
    chk("b2b_err1", a_rdyout, 0);
    chk("b2b_cnt2", a_ecnt, 2);
    tick();
    chk("b2b_err2", a_resp, 2'b01);
    chk("b2b_err2_cnt", a_ecnt, 2);
    tick();
    chk("b2b_ok_resp", a_resp, 2'b00);
    tick();
    chk("b2b_next_err1", a_rdyout, 0);
    chk("b2b_cnt3", a_ecnt, 3);
    for (int i = 0; i < 3 * 256; i++) tick();
    chk("sat_errcnt", a_ecnt, 255);

    drive_a(2'b00, 32'h0, 0, 0);
    tick(); tick(); tick();
    chk("pre_abort_resp", a_resp, 2'b00);
    drive_a(2'b10, 32'h8C00_0000, 0, 0);
    tick();
    chk("abort_in_err1", a_rdyout, 0);
    chk("sat_hold", a_ecnt, 255);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_hresp", a_resp, 2'b00);
    chk("abort_hreadyout", a_rdyout, 1);
    chk("abort_errcnt", a_ecnt, 0);
    @(negedge clk);
    rst = 1'b0;
    drive_a(2'b10, 32'h8800_0000, 1, 32'hCAFE_0001);
    chk("post_rst_valid", a_valid, 1);
    chk("post_rst_sel", a_sel, 3'b100);
    tick();
    chk("post_rst_hresp", a_resp, 2'b00);
    chk("post_rst_haddr1", a_addr1, 32'h8800_0000);

    b_trans = 2'b10; b_addr = 32'h9FFF_FFFC; b_write = 1; b_wdata = 64'hDEAD_BEEF_0123_4567;
    #1;
    chk("b_top_sel", b_sel, 8'h80);
    chk("b_top_valid", b_valid, 1);
    tick();
    chk("b_hwdata1", b_wd1, 64'hDEAD_BEEF_0123_4567);
    b_addr = 32'hA000_0000;
    #1;
    chk("b_unm_sel", b_sel, 8'h00);
    chk("b_unm_valid", b_valid, 0);
    tick();
    b_trans = 2'b00;
    chk("b_err1_hresp", b_resp, 2'b01);
    chk("b_err1_hreadyout", b_rdyout, 0);
    chk("b_errcnt", b_ecnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
